// File: rtl/wdog_pkg.sv
//------------------------------------------------------------------------------
// Module  : wdog_pkg
// Brief   : Shared types and defaults for the windowed watchdog supervisor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wdog_pkg;

    localparam int WDOG_CNT_W   = 16;
    localparam int WDOG_STATE_W = 2;

    typedef enum logic [WDOG_STATE_W-1:0] {
        WDOG_DIS   = 2'd0,
        WDOG_ARMED = 2'd1,
        WDOG_WARN  = 2'd2,
        WDOG_FIRE  = 2'd3
    } wdog_state_e;

endpackage

`default_nettype wire

// File: rtl/wdog_ticker.sv
//------------------------------------------------------------------------------
// Module  : wdog_ticker
// Brief   : Saturating up-counter with synchronous clear and terminal-match flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wdog_ticker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] match,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear beats increment; the count parks at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q == match);

endmodule

`default_nettype wire

// File: rtl/watchdog_supervisor.sv
//------------------------------------------------------------------------------
// Module  : watchdog_supervisor
// Brief   : Windowed two-stage watchdog (warn IRQ, then timed reset request).
//           Optional macro WDOG_LOCK_EN: sticky lock of enable/config at arming.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module watchdog_supervisor
    import wdog_pkg::*;
#(
    parameter int CNT_W     = WDOG_CNT_W,
    parameter int RST_PULSE = 8,
    parameter int MAX_EARLY = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_en,
    input  logic [CNT_W-1:0]        cfg_timeout,
    input  logic [CNT_W-1:0]        cfg_win_open,
    input  logic [CNT_W-1:0]        cfg_warn,
    input  logic                    kick,
    output logic                    irq_warn,
    output logic                    rst_req,
    output logic                    kick_err,
    output logic [WDOG_STATE_W-1:0] state_o
);

    localparam int EW = $clog2(MAX_EARLY + 1);
    localparam int PW = $clog2(RST_PULSE + 1);
    localparam logic [EW-1:0] EARLY_LIMIT = EW'(MAX_EARLY);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE - 1);

    localparam logic [WDOG_STATE_W-1:0] ST_DIS   = WDOG_DIS;
    localparam logic [WDOG_STATE_W-1:0] ST_ARMED = WDOG_ARMED;
    localparam logic [WDOG_STATE_W-1:0] ST_WARN  = WDOG_WARN;
    localparam logic [WDOG_STATE_W-1:0] ST_FIRE  = WDOG_FIRE;

    logic [WDOG_STATE_W-1:0] state_q, state_d;
    logic [EW-1:0]           early_q, early_d;
    logic [PW-1:0]           pulse_q, pulse_d;
    logic                    irq_warn_q, irq_warn_d;
    logic                    rst_req_q, rst_req_d;
    logic                    kick_err_q, kick_err_d;

    logic                    en_eff;
    logic [CNT_W-1:0]        timeout_eff, win_eff, warn_eff;
    logic [CNT_W-1:0]        tc_match;
    logic [CNT_W-1:0]        cnt;
    logic                    cnt_hit, cnt_clr, cnt_inc;

`ifdef WDOG_LOCK_EN
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] tmo_q, tmo_d, win_q, win_d, wrn_q, wrn_d;
    logic             arming;

    // Configuration is snapshotted on the first arm and the enable is pinned high.
    always_comb begin
        arming      = (state_q == ST_DIS) && cfg_en;
        lock_d      = lock_q | arming;
        tmo_d       = arming ? cfg_timeout  : tmo_q;
        win_d       = arming ? cfg_win_open : win_q;
        wrn_d       = arming ? cfg_warn     : wrn_q;
        en_eff      = cfg_en | lock_q;
        timeout_eff = lock_q ? tmo_q : cfg_timeout;
        win_eff     = lock_q ? win_q : cfg_win_open;
        warn_eff    = lock_q ? wrn_q : cfg_warn;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
            tmo_q  <= '0;
            win_q  <= '0;
            wrn_q  <= '0;
        end else begin
            lock_q <= lock_d;
            tmo_q  <= tmo_d;
            win_q  <= win_d;
            wrn_q  <= wrn_d;
        end
    end
`else
    always_comb begin
        en_eff      = cfg_en;
        timeout_eff = cfg_timeout;
        win_eff     = cfg_win_open;
        warn_eff    = cfg_warn;
    end
`endif

    // A zero duration behaves as one cycle, so the terminal value is max(d,1)-1.
    always_comb begin
        tc_match = '0;
        if (state_q == ST_WARN) begin
            if (warn_eff != '0) tc_match = warn_eff - CNT_W'(1);
        end else begin
            if (timeout_eff != '0) tc_match = timeout_eff - CNT_W'(1);
        end
    end

    wdog_ticker #(
        .CNT_W (CNT_W)
    ) u_ticker (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .match (tc_match),
        .cnt_o (cnt),
        .hit_o (cnt_hit)
    );

    always_comb begin
        state_d    = state_q;
        early_d    = early_q;
        pulse_d    = pulse_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        kick_err_d = 1'b0;

        case (state_q)
            ST_DIS: begin
                cnt_clr = 1'b1;
                early_d = '0;
                if (en_eff) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!en_eff) begin
                    state_d = ST_DIS;
                    cnt_clr = 1'b1;
                    early_d = '0;
                end else if (kick && (cnt >= win_eff)) begin
                    cnt_clr = 1'b1;
                    early_d = '0;
                end else if (cnt_hit) begin
                    state_d = ST_WARN;
                    cnt_clr = 1'b1;
                end else if (kick) begin
                    // Early kick: counter holds its value for this cycle.
                    kick_err_d = 1'b1;
                    if ((early_q + EW'(1)) == EARLY_LIMIT) begin
                        state_d = ST_FIRE;
                        cnt_clr = 1'b1;
                        pulse_d = '0;
                        early_d = '0;
                    end else begin
                        early_d = early_q + EW'(1);
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_WARN: begin
                if (!en_eff) begin
                    state_d = ST_DIS;
                    cnt_clr = 1'b1;
                    early_d = '0;
                end else if (kick) begin
                    state_d = ST_ARMED;
                    cnt_clr = 1'b1;
                    early_d = '0;
                end else if (cnt_hit) begin
                    state_d = ST_FIRE;
                    cnt_clr = 1'b1;
                    pulse_d = '0;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_FIRE: begin
                cnt_clr = 1'b1;
                if (pulse_q == PULSE_LAST) begin
                    state_d = en_eff ? ST_ARMED : ST_DIS;
                    early_d = '0;
                    pulse_d = '0;
                end else begin
                    pulse_d = pulse_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_DIS;
                cnt_clr = 1'b1;
            end
        endcase

        irq_warn_d = (state_d == ST_WARN);
        rst_req_d  = (state_d == ST_FIRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_DIS;
            early_q    <= '0;
            pulse_q    <= '0;
            irq_warn_q <= 1'b0;
            rst_req_q  <= 1'b0;
            kick_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            early_q    <= early_d;
            pulse_q    <= pulse_d;
            irq_warn_q <= irq_warn_d;
            rst_req_q  <= rst_req_d;
            kick_err_q <= kick_err_d;
        end
    end

    assign irq_warn = irq_warn_q;
    assign rst_req  = rst_req_q;
    assign kick_err = kick_err_q;
    assign state_o  = state_q;

endmodule

`default_nettype wire
